bfis_query_streamer: RTL

Transmitter side of the bfis vertex-input interface. On a start pulse it fetches the DIM coordinate words of the entry vertex from graph memory over the standard request/response memory port. It then drives them to bfis as a contiguous vertex_valid burst with the vertex address held stable, and waits for bfis valid_out. It captures the top-k result words and signals done, or signals an error on timeout. It sits between the host/control logic and bfis, and takes a spare graph_memory port.

---
 rtl/bfis_pkg.sv | 33 +++
 rtl/bfis_query_streamer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/bfis_pkg.sv
`default_nettype none
// ============================================================================
// Module : bfis_pkg
// Brief  : Shared types and constants for the bfis search datapath.
// Rev    : 1.0  initial release
// ============================================================================
package bfis_pkg;

    localparam int ADDR_W        = 32;
    localparam int DATA_W        = 32;
    localparam int K_OUT_DEFAULT = 5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_COLLECT = 3'd2,
        ST_STREAM  = 3'd3,
        ST_WAIT    = 3'd4,
        ST_FINISH  = 3'd5
    } streamer_state_t;

    // Word address of coordinate idx of vertex entry; wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] coord_addr(
        input logic [ADDR_W-1:0] base,
        input logic [ADDR_W-1:0] entry,
        input logic [ADDR_W-1:0] dim,
        input logic [ADDR_W-1:0] idx
    );
        return base + entry * dim + idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bfis_query_streamer.sv
`default_nettype none
// ============================================================================
// Module : bfis_query_streamer
// Brief  : Fetches the entry vertex from graph memory, streams it into bfis
//          and captures the top-k result (or flags a timeout).
// Rev    : 1.0  initial release
// ============================================================================
module bfis_query_streamer
    import bfis_pkg::*;
#(
    parameter int          DIM            = 2,
    parameter logic [31:0] POS_BASE       = 32'h0000_0000,
    parameter int          K_OUT          = K_OUT_DEFAULT,
    parameter int          TIMEOUT_CYCLES = 0
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          start_in,
    input  logic [ADDR_W-1:0]             entry_addr_in,
    output logic                          busy_out,
    output logic [ADDR_W-1:0]             mem_req_out,
    output logic                          mem_valid_out,
    input  logic [DATA_W-1:0]             mem_data_in,
    input  logic                          mem_valid_in,
    output logic [DATA_W-1:0]             vertex_out,
    output logic [ADDR_W-1:0]             vertex_addr_out,
    output logic                          vertex_valid_out,
    input  logic                          search_valid_in,
    input  logic [K_OUT-1:0][DATA_W-1:0]  top_k_in,
    output logic [K_OUT-1:0][DATA_W-1:0]  result_out,
    output logic                          done_out,
    output logic                          error_out
);

    localparam int CNT_W = $clog2(DIM + 1);
    localparam int IDX_W = (DIM > 1) ? $clog2(DIM) : 1;

    localparam logic [CNT_W-1:0]  c_dim      = CNT_W'(DIM);
    localparam logic [CNT_W-1:0]  c_dim_m1   = CNT_W'(DIM - 1);
    localparam logic [ADDR_W-1:0] c_dim_a    = ADDR_W'(DIM);
    localparam logic [31:0]       c_timeout  = 32'(TIMEOUT_CYCLES);
    localparam logic              c_to_en    = (TIMEOUT_CYCLES != 0);

    streamer_state_t             r_state;
    logic [ADDR_W-1:0]           r_entry;
    logic [CNT_W-1:0]            r_req_cnt;
    logic [CNT_W-1:0]            r_rsp_cnt;
    logic [CNT_W-1:0]            r_str_cnt;
    logic [31:0]                 r_wait_cnt;
    logic [DATA_W-1:0]           r_buf [0:DIM-1];

    logic                        r_busy;
    logic [ADDR_W-1:0]           r_mem_req;
    logic                        r_mem_valid;
    logic [DATA_W-1:0]           r_vout;
    logic [ADDR_W-1:0]           r_vaddr;
    logic                        r_vvalid;
    logic [K_OUT-1:0][DATA_W-1:0] r_result;
    logic                        r_done;
    logic                        r_error;

    logic [DATA_W-1:0]           w_first_word;
    logic [ADDR_W-1:0]           w_next_req;

    // With DIM==1 the only coordinate is still on the response bus when streaming begins.
    assign w_first_word = (DIM == 1) ? mem_data_in : r_buf[0];
    assign w_next_req   = coord_addr(POS_BASE, r_entry, c_dim_a,
                                     ADDR_W'(r_req_cnt) + ADDR_W'(1));

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state     <= ST_IDLE;
            r_entry     <= '0;
            r_req_cnt   <= '0;
            r_rsp_cnt   <= '0;
            r_str_cnt   <= '0;
            r_wait_cnt  <= '0;
            for (int i = 0; i < DIM; i++) begin
                r_buf[i] <= '0;
            end
            r_busy      <= 1'b0;
            r_mem_req   <= '0;
            r_mem_valid <= 1'b0;
            r_vout      <= '0;
            r_vaddr     <= '0;
            r_vvalid    <= 1'b0;
            r_result    <= '0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_error <= 1'b0;
                    r_vaddr <= '0;
                    if (start_in) begin
                        r_entry     <= entry_addr_in;
                        r_busy      <= 1'b1;
                        r_req_cnt   <= '0;
                        r_rsp_cnt   <= '0;
                        r_mem_valid <= 1'b1;
                        r_mem_req   <= coord_addr(POS_BASE, entry_addr_in, c_dim_a, '0);
                        r_state     <= ST_FETCH;
                    end
                end

                ST_FETCH, ST_COLLECT: begin
                    // FETCH keeps one extra cycle after the last request so a
                    // latency-1 final response can go straight to STREAM.
                    if (r_state == ST_FETCH) begin
                        if (r_req_cnt == c_dim) begin
                            r_state <= ST_COLLECT;
                        end else if (r_req_cnt == c_dim_m1) begin
                            r_mem_valid <= 1'b0;
                            r_mem_req   <= '0;
                            r_req_cnt   <= c_dim;
                        end else begin
                            r_req_cnt <= r_req_cnt + 1'b1;
                            r_mem_req <= w_next_req;
                        end
                    end
                    if (mem_valid_in) begin
                        r_buf[r_rsp_cnt[IDX_W-1:0]] <= mem_data_in;
                        r_rsp_cnt <= r_rsp_cnt + 1'b1;
                        if (r_rsp_cnt == c_dim_m1) begin
                            r_mem_valid <= 1'b0;
                            r_mem_req   <= '0;
                            r_vvalid    <= 1'b1;
                            r_vout      <= w_first_word;
                            r_vaddr     <= r_entry;
                            r_str_cnt   <= CNT_W'(1);
                            r_state     <= ST_STREAM;
                        end
                    end
                end

                ST_STREAM: begin
                    if (r_str_cnt == c_dim) begin
                        r_vvalid   <= 1'b0;
                        r_vout     <= '0;
                        r_wait_cnt <= 32'd1;
                        r_state    <= ST_WAIT;
                    end else begin
                        r_vout    <= r_buf[r_str_cnt[IDX_W-1:0]];
                        r_str_cnt <= r_str_cnt + 1'b1;
                    end
                end

                ST_WAIT: begin
                    if (search_valid_in) begin
                        r_result <= top_k_in;
                        r_done   <= 1'b1;
                        r_vaddr  <= '0;
                        r_state  <= ST_FINISH;
                    end else if (c_to_en && (r_wait_cnt == c_timeout)) begin
                        r_error  <= 1'b1;
                        r_vaddr  <= '0;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 32'd1;
                    end
                end

                ST_FINISH: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_out         = r_busy;
    assign mem_req_out      = r_mem_req;
    assign mem_valid_out    = r_mem_valid;
    assign vertex_out       = r_vout;
    assign vertex_addr_out  = r_vaddr;
    assign vertex_valid_out = r_vvalid;
    assign result_out       = r_result;
    assign done_out         = r_done;
    assign error_out        = r_error;

endmodule
`default_nettype wire
